// File: rtl/decode_pkg.sv
// Shared widths, opcode values and field-position helpers for the decode stage.
package decode_pkg;

  localparam int unsigned DEF_IR_W        = 32;
  localparam int unsigned DEF_OPCODE_W    = 8;
  localparam int unsigned DEF_REG_ADDR_W  = 4;
  localparam int unsigned DEF_IMM_W       = 16;
  localparam int unsigned DEF_STALL_CNT_W = 16;

  localparam int unsigned NOP = 0;
  localparam int unsigned LDA = 1;
  localparam int unsigned STA = 2;
  localparam int unsigned ADD = 3;
  localparam int unsigned SUB = 4;
  localparam int unsigned AND = 5;
  localparam int unsigned OR  = 6;

  // Opcode occupies the top OPCODE_W bits of the instruction word.
  function automatic int unsigned opcode_lsb(input int unsigned ir_w,
                                             input int unsigned opcode_w);
    return ir_w - opcode_w;
  endfunction

  // The primary register field sits directly below the opcode.
  function automatic int unsigned rf_lsb(input int unsigned ir_w,
                                         input int unsigned opcode_w,
                                         input int unsigned reg_addr_w);
    return ir_w - opcode_w - reg_addr_w;
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Busy-register scoreboard: tracks in-flight destinations, answers hazard queries.
module decode_scoreboard
  import decode_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       wb_valid_i,
  input  logic [REG_ADDR_W-1:0]      wb_rd_i,
  input  logic                       set_valid_i,
  input  logic [REG_ADDR_W-1:0]      set_rd_i,
  input  logic [REG_ADDR_W-1:0]      rs1_i,
  input  logic                       rs1_used_i,
  input  logic [REG_ADDR_W-1:0]      rs2_i,
  input  logic                       rs2_used_i,
  input  logic [REG_ADDR_W-1:0]      rd_i,
  input  logic                       rd_used_i,
  output logic                       hazard_o,
  output logic [2**REG_ADDR_W-1:0]   busy_o
);

  localparam int unsigned NUM_REGS = 2**REG_ADDR_W;

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] busy_eff, wb_mask, set_mask;

  // Writeback bypass, hazard query and next busy vector (set beats same-cycle clear).
  always_comb begin
    wb_mask  = '0;
    set_mask = '0;
    if (wb_valid_i)  wb_mask[wb_rd_i]   = 1'b1;
    if (set_valid_i) set_mask[set_rd_i] = 1'b1;
    busy_eff = busy_q & ~wb_mask;
    hazard_o = (rs1_used_i && busy_eff[rs1_i]) ||
               (rs2_used_i && busy_eff[rs2_i]) ||
               (rd_used_i  && busy_eff[rd_i]);
    busy_d   = flush_i ? '0 : (busy_eff | set_mask);
  end

  // Busy vector register.
  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/decode_stage.sv
// Registered instruction decode with valid/ready handshake and hazard stalling.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned IR_W        = DEF_IR_W,
  parameter int unsigned OPCODE_W    = DEF_OPCODE_W,
  parameter int unsigned REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int unsigned IMM_W       = DEF_IMM_W,
  parameter int unsigned STALL_CNT_W = DEF_STALL_CNT_W
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [IR_W-1:0]           i_ir,
  input  logic                      i_flush,
  input  logic                      i_wb_valid,
  input  logic [REG_ADDR_W-1:0]     i_wb_rd,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [OPCODE_W-1:0]       o_opcode,
  output logic [REG_ADDR_W-1:0]     o_rs1,
  output logic [REG_ADDR_W-1:0]     o_rs2,
  output logic [REG_ADDR_W-1:0]     o_rd,
  output logic [IMM_W-1:0]          o_imm,
  output logic                      o_writes_rd,
  output logic                      o_illegal,
  output logic [2**REG_ADDR_W-1:0]  o_busy,
  output logic [STALL_CNT_W-1:0]    o_stall_cycles
);

  localparam int unsigned OPC_LSB = opcode_lsb(IR_W, OPCODE_W);
  localparam int unsigned RF_LSB  = rf_lsb(IR_W, OPCODE_W, REG_ADDR_W);

  typedef struct packed {
    logic [OPCODE_W-1:0]   opcode;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [IMM_W-1:0]      imm;
    logic                  writes_rd;
    logic                  illegal;
  } dec_t;

  dec_t                   dec, out_q, out_d;
  logic                   reads_rs1, reads_rs2;
  logic                   valid_q, valid_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   sb_hazard, hazard, accept;
  logic [REG_ADDR_W-1:0]  ir_rf;

  // Not every instruction bit feeds a field for every format.
  logic unused_ir;
  assign unused_ir = ^i_ir;

  assign ir_rf = i_ir[RF_LSB +: REG_ADDR_W];

  // Field extraction; fields an opcode does not use stay zero.
  always_comb begin
    dec        = '0;
    reads_rs1  = 1'b0;
    reads_rs2  = 1'b0;
    dec.opcode = i_ir[OPC_LSB +: OPCODE_W];
    case (dec.opcode)
      OPCODE_W'(NOP): ;
      OPCODE_W'(LDA): begin
        dec.rd        = ir_rf;
        dec.imm       = i_ir[IMM_W-1:0];
        dec.writes_rd = 1'b1;
      end
      OPCODE_W'(STA): begin
        dec.rs1   = ir_rf;
        dec.imm   = i_ir[IMM_W-1:0];
        reads_rs1 = 1'b1;
      end
      OPCODE_W'(ADD), OPCODE_W'(SUB), OPCODE_W'(AND), OPCODE_W'(OR): begin
        dec.rd        = ir_rf;
        dec.rs1       = i_ir[2*REG_ADDR_W-1:REG_ADDR_W];
        dec.rs2       = i_ir[REG_ADDR_W-1:0];
        dec.writes_rd = 1'b1;
        reads_rs1     = 1'b1;
        reads_rs2     = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  decode_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_scoreboard (
    .clk_i       (i_clk),
    .rst_i       (i_reset),
    .flush_i     (i_flush),
    .wb_valid_i  (i_wb_valid),
    .wb_rd_i     (i_wb_rd),
    .set_valid_i (accept && dec.writes_rd),
    .set_rd_i    (dec.rd),
    .rs1_i       (dec.rs1),
    .rs1_used_i  (reads_rs1),
    .rs2_i       (dec.rs2),
    .rs2_used_i  (reads_rs2),
    .rd_i        (dec.rd),
    .rd_used_i   (dec.writes_rd),
    .hazard_o    (sb_hazard),
    .busy_o      (o_busy)
  );

  assign hazard  = i_valid && sb_hazard;
  assign o_ready = !i_flush && !hazard && (!valid_q || i_ready);
  assign accept  = i_valid && o_ready;

  // Output register next state: flush drops valid, accept loads, drain clears valid only.
  always_comb begin
    valid_d = valid_q;
    out_d   = out_q;
    stall_d = stall_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      out_d   = dec;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
    if (hazard && !i_flush && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  // Output and counter registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      out_q   <= out_d;
      stall_q <= stall_d;
    end
  end

  assign o_valid        = valid_q;
  assign o_opcode       = out_q.opcode;
  assign o_rs1          = out_q.rs1;
  assign o_rs2          = out_q.rs2;
  assign o_rd           = out_q.rd;
  assign o_imm          = out_q.imm;
  assign o_writes_rd    = out_q.writes_rd;
  assign o_illegal      = out_q.illegal;
  assign o_stall_cycles = stall_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode table, directed sequences, random vs model.
module tb_decode_stage;

  localparam int unsigned CW = 4;  // small counter so saturation is reachable

  logic        clk;
  logic        rst, vin, rdy_o, flush, wbv, vout, rdy_in, wr, ill;
  logic [31:0] ir;
  logic [3:0]  wbrd, rs1, rs2, rd;
  logic [7:0]  op;
  logic [15:0] imm, busy;
  logic [CW-1:0] cnt;

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  decode_stage #(
    .IR_W(32), .OPCODE_W(8), .REG_ADDR_W(4), .IMM_W(16), .STALL_CNT_W(CW)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(vin), .o_ready(rdy_o), .i_ir(ir),
    .i_flush(flush), .i_wb_valid(wbv), .i_wb_rd(wbrd), .o_valid(vout),
    .i_ready(rdy_in), .o_opcode(op), .o_rs1(rs1), .o_rs2(rs2), .o_rd(rd),
    .o_imm(imm), .o_writes_rd(wr), .o_illegal(ill), .o_busy(busy),
    .o_stall_cycles(cnt)
  );

  typedef struct {
    logic [7:0]  op;
    logic [3:0]  rs1, rs2, rd;
    logic [15:0] imm;
    bit          wr, ill;
    logic [15:0] uses;
  } dec_t;

  typedef struct {
    logic [31:0] ir;
    logic [7:0]  op;
    logic [3:0]  rs1, rs2, rd;
    logic [15:0] imm;
    bit          wr, ill;
  } vec_t;

  // Reference model state
  bit          m_v;
  dec_t        m_d;
  logic [15:0] m_busy;
  int          m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t d;
    d = '{default: 0};
    d.op = w[31:24];
    case (w[31:24])
      8'd0: ;
      8'd1: begin d.rd = w[23:20]; d.imm = w[15:0]; d.wr = 1; end
      8'd2: begin d.rs1 = w[23:20]; d.imm = w[15:0]; end
      8'd3, 8'd4, 8'd5, 8'd6: begin
        d.rd = w[23:20]; d.rs1 = w[7:4]; d.rs2 = w[3:0]; d.wr = 1;
      end
      default: d.ill = 1;
    endcase
    // Registers whose in-flight status matters to this instruction
    if (w[31:24] == 8'd2) d.uses |= 16'(1) << d.rs1;
    if (w[31:24] >= 8'd3 && w[31:24] <= 8'd6)
      d.uses |= (16'(1) << d.rs1) | (16'(1) << d.rs2);
    if (d.wr) d.uses |= 16'(1) << d.rd;
    return d;
  endfunction

  task automatic model_reset();
    m_v = 0; m_d = '{default: 0}; m_busy = '0; m_cnt = 0;
  endtask

  // One clock: check o_ready before the edge, advance model, check outputs after.
  task automatic cyc();
    dec_t d;
    logic [15:0] eff;
    bit hz, rdy, acc;
    #1;
    d   = ref_decode(ir);
    eff = m_busy;
    if (wbv) eff[wbrd] = 1'b0;
    hz  = vin && ((d.uses & eff) != 16'd0);
    rdy = !flush && !hz && (!m_v || rdy_in);
    acc = vin && rdy;
    if (!rst) check("ready", 64'(rdy_o), 64'(rdy));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (flush) begin
      m_v = 0; m_busy = '0;
    end else begin
      if (acc) begin m_v = 1; m_d = d; end
      else if (m_v && rdy_in) m_v = 0;
      m_busy = eff | ((acc && d.wr) ? (16'(1) << d.rd) : 16'd0);
      if (hz && m_cnt < (2**CW - 1)) m_cnt++;
    end
    @(negedge clk);
    check("outs", 64'({vout, op, rs1, rs2, rd, imm, wr, ill}),
          64'({m_v, m_d.op, m_d.rs1, m_d.rs2, m_d.rd, m_d.imm, m_d.wr, m_d.ill}));
    check("busy", 64'(busy), 64'(m_busy));
    check("stall_cnt", 64'(cnt), 64'(m_cnt));
  endtask

  function automatic logic [31:0] rand_ir();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 9);
    w[31:24] = (k <= 6) ? 8'(k) : 8'($urandom_range(7, 255));
    w[23] = 1'b0; w[7] = 1'b0; w[3] = 1'b0;  // r0..r7 only, to provoke hazards
    return w;
  endfunction

  vec_t tbl[10];

  initial begin
    tbl[0] = '{32'h00FFFFFF, 8'h00, 4'h0, 4'h0, 4'h0, 16'h0000, 0, 0};
    tbl[1] = '{32'h01301234, 8'h01, 4'h0, 4'h0, 4'h3, 16'h1234, 1, 0};
    tbl[2] = '{32'h02A0BEEF, 8'h02, 4'hA, 4'h0, 4'h0, 16'hBEEF, 0, 0};
    tbl[3] = '{32'h03500032, 8'h03, 4'h3, 4'h2, 4'h5, 16'h0000, 1, 0};
    tbl[4] = '{32'h04C0FF9E, 8'h04, 4'h9, 4'hE, 4'hC, 16'h0000, 1, 0};
    tbl[5] = '{32'h05100011, 8'h05, 4'h1, 4'h1, 4'h1, 16'h0000, 1, 0};
    tbl[6] = '{32'h06F000AB, 8'h06, 4'hA, 4'hB, 4'hF, 16'h0000, 1, 0};
    tbl[7] = '{32'hEE123456, 8'hEE, 4'h0, 4'h0, 4'h0, 16'h0000, 0, 1};
    tbl[8] = '{32'h07FFFFFF, 8'h07, 4'h0, 4'h0, 4'h0, 16'h0000, 0, 1};
    tbl[9] = '{32'hFF000000, 8'hFF, 4'h0, 4'h0, 4'h0, 16'h0000, 0, 1};

    rst = 1; vin = 0; ir = '0; flush = 0; wbv = 0; wbrd = '0; rdy_in = 1;
    model_reset();
    @(negedge clk);
    cyc();
    rst = 0;
    #1;
    check("reset_state", 64'({vout, busy, cnt, rdy_o}), 64'({1'b0, 16'h0, 4'h0, 1'b1}));

    // Decode table
    for (int i = 0; i < 10; i++) begin
      vin = 1; ir = tbl[i].ir;
      cyc();
      check($sformatf("tbl%0d_fields", i), 64'({vout, op, rs1, rs2, rd, imm, wr, ill}),
            64'({1'b1, tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].imm,
                 tbl[i].wr, tbl[i].ill}));
      check($sformatf("tbl%0d_busy", i), 64'(busy),
            64'(tbl[i].wr ? (16'(1) << tbl[i].rd) : 16'd0));
      vin = 0; flush = 1;
      cyc();
      flush = 0;
    end

    // Fresh start
    rst = 1; cyc(); rst = 0;

    // LDA r3 then dependent ADD stalls until writeback of r3
    vin = 1; ir = 32'h01301234;
    cyc();
    check("lda_out", 64'({vout, op, rd, imm, wr}), 64'({1'b1, 8'h01, 4'h3, 16'h1234, 1'b1}));
    check("lda_busy3", 64'(busy[3]), 64'(1));
    ir = 32'h03500032;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      check("raw_ready", 64'(rdy_o), 64'(0));
      check($sformatf("raw_stall%0d", k), 64'(cnt), 64'(k));
    end
    wbv = 1; wbrd = 4'd3;
    #1 check("wb_ready", 64'(rdy_o), 64'(1));
    cyc();
    wbv = 0;
    check("add_out", 64'({vout, op, rs1, rs2, rd}), 64'({1'b1, 8'h03, 4'h3, 4'h2, 4'h5}));
    check("add_busy", 64'(busy), 64'(16'h0020));

    // Downstream backpressure holds everything
    rdy_in = 0; ir = 32'h02100000;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("bp_hold", 64'({vout, op, rd, rdy_o}), 64'({1'b1, 8'h03, 4'h5, 1'b0}));
    end
    rdy_in = 1;
    cyc();
    check("bp_release", 64'({vout, op, rs1, imm}), 64'({1'b1, 8'h02, 4'h1, 16'h0000}));
    vin = 0;
    cyc();

    // Flush with r3,r5 busy
    vin = 1; ir = 32'h01300000;
    cyc();
    check("pre_flush_busy", 64'(busy), 64'(16'h0028));
    flush = 1; ir = 32'h01900000;
    #1 check("flush_ready", 64'(rdy_o), 64'(0));
    cyc();
    check("flush_out", 64'({vout, busy}), 64'({1'b0, 16'h0000}));
    flush = 0; vin = 0; wbv = 1; wbrd = 4'd3;
    cyc();
    check("wb_after_flush", 64'(busy), 64'(16'h0000));

    // Set wins over same-cycle writeback
    vin = 1; ir = 32'h01700000; wbrd = 4'd7;
    cyc();
    wbv = 0;
    check("set_wins", 64'(busy), 64'(16'h0080));

    // Illegal opcode
    ir = 32'hEE123456;
    cyc();
    check("illegal_out", 64'({vout, op, rs1, rs2, rd, imm, wr, ill}),
          64'({1'b1, 8'hEE, 4'h0, 4'h0, 4'h0, 16'h0, 1'b0, 1'b1}));
    check("illegal_busy", 64'(busy), 64'(16'h0080));
    vin = 0;
    cyc();

    // Stall counter saturates
    vin = 1; ir = 32'h03100077;
    for (int k = 0; k < 20; k++) cyc();
    check("stall_sat", 64'(cnt), 64'((2**CW) - 1));

    // Reset mid-operation
    rst = 1;
    cyc();
    rst = 0; vin = 0;
    check("mid_reset", 64'({vout, op, rd, imm, busy, cnt}), 64'(0));

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst    = ($urandom_range(0, 299) == 0);
      vin    = ($urandom_range(0, 3) != 0);
      ir     = rand_ir();
      rdy_in = ($urandom_range(0, 9) < 7);
      flush  = ($urandom_range(0, 24) == 0);
      wbv    = ($urandom_range(0, 2) == 0);
      wbrd   = 4'($urandom_range(0, 7));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised successor to the combinational instruction decoder.
- Decodes one instruction word per cycle into opcode, register indices and immediate, behind a valid/ready handshake on both sides.
- Tracks in-flight destination registers in a scoreboard and stalls on RAW/WAW hazards until writeback clears them.
- Supports flush and flags illegal opcodes. Sits between fetch and execute.

Parameters:
- IR_W, 32, instruction word width. Must satisfy IR_W >= OPCODE_W+REG_ADDR_W+IMM_W and IMM_W >= 2*REG_ADDR_W.
- OPCODE_W, 8, opcode field width, taken from IR[IR_W-1 -: OPCODE_W].
- REG_ADDR_W, 4, register index width. NUM_REGS = 2**REG_ADDR_W.
- IMM_W, 16, immediate field width, taken from IR[IMM_W-1:0].
- STALL_CNT_W, 16, width of the saturating hazard-stall counter.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset. One clock; reset is synchronous and active-high.
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  decode can accept this cycle.
- i_ir  in  IR_W  instruction word.
- i_flush  in  1  discard output register and clear scoreboard.
- i_wb_valid  in  1  writeback retiring a register.
- i_wb_rd  in  REG_ADDR_W  register being written back.
- o_valid  out  1  decoded instruction valid.
- i_ready  in  1  downstream accepts.
- o_opcode  out  OPCODE_W  decoded opcode.
- o_rs1  out  REG_ADDR_W  source register 1.
- o_rs2  out  REG_ADDR_W  source register 2.
- o_rd  out  REG_ADDR_W  destination register.
- o_imm  out  IMM_W  immediate.
- o_writes_rd  out  1  instruction writes o_rd.
- o_illegal  out  1  opcode not recognised.
- o_busy  out  NUM_REGS  scoreboard vector (debug).
- o_stall_cycles  out  STALL_CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Reset: every output register is 0, the scoreboard is 0 and the counter is 0. o_ready then evaluates to 1.
- Field extraction: RF = IR[IR_W-OPCODE_W-1 -: REG_ADDR_W].
  - NOP=0: all fields 0.
  - LDA=1: rd=RF, imm=IR[IMM_W-1:0], writes_rd=1.
  - STA=2: rs1=RF, imm=IR[IMM_W-1:0].
  - ADD=3, SUB=4, AND=5, OR=6: rd=RF, rs1=IR[2*REG_ADDR_W-1:REG_ADDR_W], rs2=IR[REG_ADDR_W-1:0], writes_rd=1.
  - Any other opcode: opcode passed through, other fields 0, illegal=1, writes_rd=0.
  - Unused fields are always 0.
- Effective busy: busy_eff = busy with bit i_wb_rd cleared when i_wb_valid. This same-cycle writeback bypass is combinational.
- Hazard: asserted when i_valid and busy_eff is set for any register the instruction actually uses (rs1 and/or rs2 as read, rd if writes_rd). Unused fields never cause a hazard.
- o_ready = !i_flush && !hazard && (!o_valid || i_ready).
- Accept = i_valid && o_ready. On accept, the output register loads the decoded fields and o_valid<=1. Latency is 1 cycle from accept to o_valid.
- If o_valid && i_ready && !accept: o_valid<=0 and the fields hold their values.
- If o_valid && !i_ready: all outputs hold stable (no change while stalled downstream).
- Scoreboard next value: busy_eff, then set bit rd on accept with writes_rd. Set wins over a same-cycle writeback to the same register.
- Flush (priority over everything except reset): o_valid<=0, scoreboard<=0, no accept that cycle. A later writeback to an already-clear bit is a no-op.
- o_stall_cycles increments on each cycle with i_valid && hazard && !i_flush, and saturates at all-ones.
- Reset mid-operation: the same state as power-on reset, with in-flight state lost.

Decomposition:
- decode_pkg holds:
  - opcode localparams NOP, LDA, STA, ADD, SUB, AND, OR;
  - the default widths;
  - a function deriving the field-extract positions.
- One sub-module, decode_scoreboard: busy vector with set, clear, flush, wb bypass and hazard query. The top keeps extract, handshake and counter.

Test Plan:
- LDA r3,#0x1234 (i_ir=0x01301234), i_ready=1. Next cycle: o_valid=1, o_opcode=1, o_rd=3, o_imm=0x1234, o_writes_rd=1, o_busy[3]=1.
- ADD r5=r3+r2 (0x03500032) presented right after that LDA. o_ready=0 and o_stall_cycles counts 1,2,3 until i_wb_valid with i_wb_rd=3. Accept occurs in the wb cycle, then o_rs1=3, o_rs2=2, o_rd=5.
- i_ready=0 with o_valid=1 for 4 cycles. Outputs stay stable, o_ready=0, and a second instruction is held upstream. Releasing i_ready accepts it next cycle.
- Same-cycle issue of LDA r7 and i_wb_rd=7. o_busy[7]=1 afterwards.
- i_flush with o_valid=1 and busy r3,r5. Next cycle: o_valid=0, o_busy=0, and the flush-cycle instruction is not accepted.
- Opcode 0xEE (0xEE123456). o_illegal=1, all fields 0, o_writes_rd=0, scoreboard unchanged.
